// File: rtl/baseline_pkg.sv
// Shared constants for the multi-rate baseline scheduler and its sliding-window datapath.
package baseline_pkg;

   localparam int SPS_DEFAULT    = 250;
   localparam int N_5S_DEFAULT   = 5;
   localparam int N_30S_DEFAULT  = 6;
   localparam int N_240S_DEFAULT = 8;

   // Window sum widths: raw sample, 1 s sum feeding the mid stages, final 240 s baseline.
   localparam int WIN_IN_W  = 16;
   localparam int WIN_MID_W = WIN_IN_W + $clog2(SPS_DEFAULT);
   localparam int WIN_OUT_W = WIN_MID_W + $clog2(N_5S_DEFAULT * N_30S_DEFAULT * N_240S_DEFAULT);

   typedef struct packed {
      logic [15:0] smp_cnt;
      logic [7:0]  s1_cnt;
      logic [7:0]  s5_cnt;
      logic [7:0]  s30_cnt;
   } sched_dbg_t;

   // Counter width for a modulus; a modulus of 1 still needs one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/baseline_sched_if.sv
// Control/strobe bundle between the sample source, the scheduler and the window datapath.
interface baseline_sched_if;
   import baseline_pkg::*;

   // din_valid is a one-cycle qualifier with no ready: the scheduler accepts every
   // strobe on a run cycle, so there is no backpressure path.
   logic       en;
   logic       din_valid;
   logic       tick_1s;
   logic       tick_5s;
   logic       tick_30s;
   logic       tick_240s;
   logic       full_5s;
   logic       full_30s;
   logic       full_240s;
   logic       out_valid;
   logic       overrun;
   sched_dbg_t dbg;

   modport master (
      output en, din_valid,
      input  tick_1s, tick_5s, tick_30s, tick_240s,
      input  full_5s, full_30s, full_240s, out_valid, overrun, dbg
   );

   modport slave (
      input  en, din_valid,
      output tick_1s, tick_5s, tick_30s, tick_240s,
      output full_5s, full_30s, full_240s, out_valid, overrun, dbg
   );

endinterface

// File: rtl/baseline_sched_rate_div.sv
// Modulo-N step counter; wrap is combinational so a cascade of these advances on one edge.
module rate_div
   import baseline_pkg::*;
#(
   parameter int N = 4,
   localparam int W = cnt_w(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         run,
   input  logic         step,
   output logic         wrap,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign wrap  = run && step && (count_q == LAST);
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (run && step) begin
         count_d = wrap ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/baseline_sched.sv
// Baseline scheduler: cascaded rate dividers issue coincident stage-load strobes and fill flags.
// Optional sticky sample-loss flag compiled in with BASELINE_SCHED_OVERRUN_EN.
module baseline_sched
   import baseline_pkg::*;
#(
   parameter int SPS    = SPS_DEFAULT,
   parameter int N_5S   = N_5S_DEFAULT,
   parameter int N_30S  = N_30S_DEFAULT,
   parameter int N_240S = N_240S_DEFAULT
) (
   input logic             clk,
   input logic             rst,
   baseline_sched_if.slave bus
);

   localparam int W_SMP = cnt_w(SPS);
   localparam int W_F5  = cnt_w(N_5S);
   localparam int W_F30 = cnt_w(N_30S);
   localparam int W_F240 = cnt_w(N_240S);

   localparam logic [W_F5-1:0]   LAST_5S   = W_F5'(N_5S - 1);
   localparam logic [W_F30-1:0]  LAST_30S  = W_F30'(N_30S - 1);
   localparam logic [W_F240-1:0] LAST_240S = W_F240'(N_240S - 1);

   logic run;
   logic w_1s, w_5s, w_30s, w_240s;
   logic [W_SMP-1:0]  cnt_smp;
   logic [W_F5-1:0]   cnt_s1;
   logic [W_F30-1:0]  cnt_s5;
   logic [W_F240-1:0] cnt_s30;

   assign run = ~bus.en;

   // Each wrap is the next stage's step, so all wrapping stages fire on the same edge.
   rate_div #(.N(SPS)) u_div_smp (
      .clk(clk), .rst(rst), .run(run), .step(bus.din_valid), .wrap(w_1s), .count(cnt_smp)
   );
   rate_div #(.N(N_5S)) u_div_1s (
      .clk(clk), .rst(rst), .run(run), .step(w_1s), .wrap(w_5s), .count(cnt_s1)
   );
   rate_div #(.N(N_30S)) u_div_5s (
      .clk(clk), .rst(rst), .run(run), .step(w_5s), .wrap(w_30s), .count(cnt_s5)
   );
   rate_div #(.N(N_240S)) u_div_30s (
      .clk(clk), .rst(rst), .run(run), .step(w_30s), .wrap(w_240s), .count(cnt_s30)
   );

   logic [3:0]        tick_q, tick_d;
   logic              out_valid_q, out_valid_d;
   logic [W_F5-1:0]   fill_5s_q, fill_5s_d;
   logic [W_F30-1:0]  fill_30s_q, fill_30s_d;
   logic [W_F240-1:0] fill_240s_q, fill_240s_d;
   logic              full_5s_q, full_5s_d;
   logic              full_30s_q, full_30s_d;
   logic              full_240s_q, full_240s_d;

   always_comb begin
      tick_d      = {w_240s, w_30s, w_5s, w_1s};
      // One cycle after a visible tick_30s whose load left the 240 s stage full.
      out_valid_d = tick_q[2] && run && full_240s_q;
      fill_5s_d   = fill_5s_q;
      fill_30s_d  = fill_30s_q;
      fill_240s_d = fill_240s_q;
      full_5s_d   = full_5s_q;
      full_30s_d  = full_30s_q;
      full_240s_d = full_240s_q;
      if (w_1s && !full_5s_q) begin
         if (fill_5s_q == LAST_5S) full_5s_d = 1'b1;
         else                      fill_5s_d = fill_5s_q + 1'b1;
      end
      if (w_5s && !full_30s_q) begin
         if (fill_30s_q == LAST_30S) full_30s_d = 1'b1;
         else                        fill_30s_d = fill_30s_q + 1'b1;
      end
      if (w_30s && !full_240s_q) begin
         if (fill_240s_q == LAST_240S) full_240s_d = 1'b1;
         else                          fill_240s_d = fill_240s_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q      <= '0;
         out_valid_q <= 1'b0;
         fill_5s_q   <= '0;
         fill_30s_q  <= '0;
         fill_240s_q <= '0;
         full_5s_q   <= 1'b0;
         full_30s_q  <= 1'b0;
         full_240s_q <= 1'b0;
      end else begin
         tick_q      <= tick_d;
         out_valid_q <= out_valid_d;
         fill_5s_q   <= fill_5s_d;
         fill_30s_q  <= fill_30s_d;
         fill_240s_q <= fill_240s_d;
         full_5s_q   <= full_5s_d;
         full_30s_q  <= full_30s_d;
         full_240s_q <= full_240s_d;
      end
   end

   // Strobes are masked while frozen so the datapath never loads during a freeze.
   assign bus.tick_1s   = tick_q[0] & run;
   assign bus.tick_5s   = tick_q[1] & run;
   assign bus.tick_30s  = tick_q[2] & run;
   assign bus.tick_240s = tick_q[3] & run;
   assign bus.out_valid = out_valid_q & run;
   assign bus.full_5s   = full_5s_q;
   assign bus.full_30s  = full_30s_q;
   assign bus.full_240s = full_240s_q;
   assign bus.dbg       = {16'(cnt_smp), 8'(cnt_s1), 8'(cnt_s5), 8'(cnt_s30)};

`ifdef BASELINE_SCHED_OVERRUN_EN
   logic overrun_q, overrun_d;

   always_comb begin
      overrun_d = overrun_q | (bus.en & bus.din_valid);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

   assign bus.overrun = overrun_q;
`else
   assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_baseline_sched.sv
// Directed bench for baseline_sched: small-config cascade, reset, sparse input, freeze, overrun.
module tb_baseline_sched;
   import baseline_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   baseline_sched_if if_s ();
   baseline_sched_if if_d ();

   baseline_sched #(.SPS(4), .N_5S(2), .N_30S(2), .N_240S(2)) u_small (
      .clk(clk), .rst(rst), .bus(if_s)
   );

   baseline_sched u_def (
      .clk(clk), .rst(rst), .bus(if_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {tick_1s, tick_5s, tick_30s, tick_240s, full_5s, full_30s, full_240s, out_valid}
   function automatic logic [7:0] outs_s();
      return {if_s.tick_1s, if_s.tick_5s, if_s.tick_30s, if_s.tick_240s,
              if_s.full_5s, if_s.full_30s, if_s.full_240s, if_s.out_valid};
   endfunction

   function automatic logic [7:0] outs_d();
      return {if_d.tick_1s, if_d.tick_5s, if_d.tick_30s, if_d.tick_240s,
              if_d.full_5s, if_d.full_30s, if_d.full_240s, if_d.out_valid};
   endfunction

   // Small config, din_valid every cycle; c = cycle number after reset release.
   function automatic logic [7:0] exp_small(input int c);
      logic t1, t5, t30, t240;
      t1   = (c > 1) && ((c - 1) % 4 == 0);
      t5   = (c > 1) && ((c - 1) % 8 == 0);
      t30  = (c > 1) && ((c - 1) % 16 == 0);
      t240 = (c > 1) && ((c - 1) % 32 == 0);
      return {t1, t5, t30, t240, (c >= 9), (c >= 17), (c >= 33), (c == 34)};
   endfunction

   initial begin
      logic [7:0] seen;
      logic [7:0] exp;
      checks = 0;
      errors = 0;

      // Reset with din_valid high and run enabled.
      rst = 1'b1;
      if_s.en = 1'b0; if_s.din_valid = 1'b1;
      if_d.en = 1'b0; if_d.din_valid = 1'b1;
      repeat (3) step();
      check("reset small outs", 32'(outs_s()), 32'h0);
      check("reset def outs", 32'(outs_d()), 32'h0);
      check("reset small overrun", 32'(if_s.overrun), 32'h0);
      check("reset def smp_cnt", 32'(if_d.dbg.smp_cnt), 32'h0);

      // Cascade: ticks at 5/9/13, tick_5s at 9, tick_30s at 17, full_240s at 33, out_valid at 34.
      rst = 1'b0;
      if_d.din_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         check($sformatf("cascade c%0d", c), 32'(outs_s()), 32'(exp_small(c)));
         step();
      end

      // Reset after 3 of 4 samples: fresh 4 samples needed, full flags clear.
      repeat (3) step();
      check("midop smp_cnt", 32'(if_s.dbg.smp_cnt), 32'd3);
      check("midop full before rst", 32'(outs_s() & 8'h0E), 32'h0E);
      rst = 1'b1;
      step();
      check("midop rst outs", 32'(outs_s()), 32'h0);
      check("midop rst smp_cnt", 32'(if_s.dbg.smp_cnt), 32'h0);
      rst = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         exp = (c == 5) ? 8'h80 : 8'h00;
         check($sformatf("midop c%0d", c), 32'(outs_s()), 32'(exp));
         step();
      end

      // Sparse input: strobe every 3rd cycle, tick_1s one cycle after every 4th strobe.
      rst = 1'b1;
      if_s.din_valid = 1'b0;
      step();
      rst = 1'b0;
      for (int c = 1; c <= 26; c++) begin
         if (c == 11)      exp = 8'h80;
         else if (c == 23) exp = 8'hC8;
         else if (c > 23)  exp = 8'h08;
         else              exp = 8'h00;
         check($sformatf("sparse c%0d", c), 32'(outs_s()), 32'(exp));
         if_s.din_valid = ((c - 1) % 3 == 0);
         step();
      end
      if_s.din_valid = 1'b0;

      // Freeze mid-second on the default config: 100 samples, 100 frozen cycles, 150 to go.
      rst = 1'b1;
      if_d.din_valid = 1'b1;
      step();
      rst = 1'b0;
      repeat (100) step();
      check("freeze pre smp_cnt", 32'(if_d.dbg.smp_cnt), 32'd100);
      if_d.en = 1'b1;
      if_d.din_valid = 1'b0;
      seen = 8'h00;
      for (int i = 0; i < 100; i++) begin
         step();
         seen = seen | outs_d();
      end
      check("freeze no ticks", 32'(seen), 32'h0);
      check("freeze held smp_cnt", 32'(if_d.dbg.smp_cnt), 32'd100);
      if_d.en = 1'b0;
      if_d.din_valid = 1'b1;
      for (int c = 1; c <= 152; c++) begin
         check($sformatf("resume c%0d", c), 32'(if_d.tick_1s), (c == 151) ? 32'h1 : 32'h0);
         step();
      end
      check("resume s1_cnt", 32'(if_d.dbg.s1_cnt), 32'd1);

      // Sample arriving while frozen.
      if_d.en = 1'b1;
      if_d.din_valid = 1'b1;
      step();
      if_d.en = 1'b0;
      if_d.din_valid = 1'b0;
`ifdef BASELINE_SCHED_OVERRUN_EN
      check("overrun set", 32'(if_d.overrun), 32'h1);
      repeat (5) step();
      check("overrun sticky", 32'(if_d.overrun), 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("overrun cleared by rst", 32'(if_d.overrun), 32'h0);
`else
      check("overrun tied low", 32'(if_d.overrun), 32'h0);
      repeat (5) step();
      check("overrun still low", 32'(if_d.overrun), 32'h0);
`endif
      check("small overrun idle", 32'(if_s.overrun), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
